// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master sharing logic: FSM states, bus field
// widths and direction encoding.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic R_W_WRITE = 1'b0;
  localparam logic R_W_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_STOP = 3'd2,
    WAIT_IDLE = 3'd3,
    ABORT     = 3'd4,
    RELEASE   = 3'd5
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping past N-1 back to 0.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int            pos;
  logic [IW-1:0] pos_c;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    pos_c = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      pos_c = IW'(pos);
      if (!found && req_i[pos_c]) begin
        found = 1'b1;
        idx_o = pos_c;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
    valid_o = found;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between NUM_REQ requesters with round-robin grants,
// completion tracking via stop_cond and a watchdog that resets a hung master.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [I2C_DATA_W-1:0]         rdata,
  output logic                          busy,
  output logic                          m_start,
  output logic                          m_r_w,
  output logic [I2C_ADDR_W-1:0]         m_slave_a,
  output logic [I2C_DATA_W-1:0]         m_data,
  input  logic [I2C_DATA_W-1:0]         m_rdata,
  input  logic                          m_stop_cond,
  output logic                          m_reset
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
  logic                  m_start_q, m_start_d;
  logic                  m_reset_q, m_reset_d;
  logic                  m_r_w_q, m_r_w_d;
  logic [I2C_ADDR_W-1:0] m_slave_a_q, m_slave_a_d;
  logic [I2C_DATA_W-1:0] m_data_q, m_data_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         winner_q, winner_d;
  logic [TO_W-1:0]       wd_q, wd_d;
  logic                  ab_q, ab_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;
  logic [TO_W-1:0]       wd_inc;
  logic                  wd_hit;

  logic [I2C_ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [I2C_DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*I2C_ADDR_W +: I2C_ADDR_W];
    assign wdata_arr[g] = req_wdata[g*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // wd_q counts cycles elapsed since the start pulse and saturates at TIMEOUT.
  assign wd_inc = (wd_q >= TO_W'(TIMEOUT)) ? wd_q : wd_q + TO_W'(1);
  assign wd_hit = (wd_inc >= TO_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    m_start_d   = 1'b0;
    m_reset_d   = 1'b1;
    m_r_w_d     = m_r_w_q;
    m_slave_a_d = m_slave_a_q;
    m_data_d    = m_data_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    wd_d        = wd_q;
    ab_d        = ab_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_gnt;
          winner_d    = pick_idx;
          m_r_w_d     = req_rw[pick_idx];
          m_slave_a_d = addr_arr[pick_idx];
          m_data_d    = wdata_arr[pick_idx];
          m_start_d   = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        wd_d    = TO_W'(1);
        state_d = WAIT_STOP;
      end
      WAIT_STOP: begin
        wd_d = wd_inc;
        if (m_stop_cond) begin
          state_d = WAIT_IDLE;
        end else if (wd_hit) begin
          m_reset_d = 1'b0;
          ab_d      = 1'b0;
          state_d   = ABORT;
        end
      end
      WAIT_IDLE: begin
        wd_d = wd_inc;
        if (!m_stop_cond) begin
          if (m_r_w_q == R_W_READ) rdata_d = m_rdata;
          done_d  = gnt_q;
          state_d = RELEASE;
        end else if (wd_hit) begin
          m_reset_d = 1'b0;
          ab_d      = 1'b0;
          state_d   = ABORT;
        end
      end
      ABORT: begin
        // Master reset spans both ABORT cycles; err lands in the second.
        if (!ab_q) begin
          ab_d      = 1'b1;
          m_reset_d = 1'b0;
          err_d     = gnt_q;
        end else begin
          ab_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = (winner_q == IW'(NUM_REQ - 1)) ? '0 : winner_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      m_start_q   <= 1'b0;
      m_reset_q   <= 1'b1;
      m_r_w_q     <= 1'b0;
      m_slave_a_q <= '0;
      m_data_q    <= '0;
      ptr_q       <= '0;
      winner_q    <= '0;
      wd_q        <= '0;
      ab_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      m_start_q   <= m_start_d;
      m_reset_q   <= m_reset_d;
      m_r_w_q     <= m_r_w_d;
      m_slave_a_q <= m_slave_a_d;
      m_data_q    <= m_data_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      wd_q        <= wd_d;
      ab_q        <= ab_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign m_start   = m_start_q;
  assign m_r_w     = m_r_w_q;
  assign m_slave_a = m_slave_a_q;
  assign m_data    = m_data_q;
  assign m_reset   = m_reset_q;

endmodule
